// File: rtl/multicycle_stage_sequencer.sv
// rtl/multicycle_stage_sequencer.sv - five-stage instruction sequencer with memory wait states, stall and fault
module multicycle_stage_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int NOP_SKIP    = 1,
    parameter int CNT_W       = 16
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Hold,
    input  logic             Mem_Ready,
    input  logic             NOP_FLAG,
    input  logic [1:0]       Mem_Access,
    input  logic             Writes_RF,
    output logic [2:0]       Stage,
    output logic             IR_Enable,
    output logic             PC_Enable,
    output logic             RA_Enable,
    output logic             RB_Enable,
    output logic             RZ_Enable,
    output logic             RM_Enable,
    output logic             RY_Enable,
    output logic             RF_WRITE,
    output logic             MA_Select,
    output logic [1:0]       MEM_r_w_z_z,
    output logic             Instr_Done,
    output logic             Mem_Fault,
    output logic [CNT_W-1:0] Instr_Count
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_FAULT     = 3'd7
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           r_state;
    logic [TO_W-1:0]  r_wait;
    logic [CNT_W-1:0] r_count;

    state_t           w_next_state;
    logic [TO_W-1:0]  w_wait_next;
    logic [1:0]       w_mem_cmd;
    logic             w_to_hit;
    logic             w_active;
    logic             w_ir, w_pc, w_ra, w_rb, w_rz, w_rm, w_ry, w_rf_wr;
    logic             w_done, w_fault, w_ma_sel;
    logic [1:0]       w_cmd;

    // 11 is an illegal access code and behaves like no access; NOPs never touch memory
    assign w_mem_cmd = (NOP_FLAG || Mem_Access == 2'b11) ? 2'b00 : Mem_Access;
    assign w_to_hit  = (MEM_TIMEOUT > 0) && (r_wait == TO_LAST);
    assign w_active  = Reset_n & ~Hold;

    always_comb begin
        w_next_state = r_state;
        w_wait_next  = r_wait;
        w_ir         = 1'b0;
        w_pc         = 1'b0;
        w_ra         = 1'b0;
        w_rb         = 1'b0;
        w_rz         = 1'b0;
        w_rm         = 1'b0;
        w_ry         = 1'b0;
        w_rf_wr      = 1'b0;
        w_done       = 1'b0;
        w_fault      = 1'b0;
        w_ma_sel     = 1'b1;
        w_cmd        = 2'b00;
        case (r_state)
            ST_FETCH: begin
                w_cmd = 2'b10;
                if (Mem_Ready) begin
                    w_ir         = 1'b1;
                    w_pc         = 1'b1;
                    w_next_state = ST_DECODE;
                    w_wait_next  = '0;
                end else if (w_to_hit) begin
                    w_next_state = ST_FAULT;
                end else begin
                    w_wait_next = r_wait + 1'b1;
                end
            end
            ST_DECODE: begin
                if (NOP_FLAG && NOP_SKIP != 0) begin
                    w_done       = 1'b1;
                    w_next_state = ST_FETCH;
                end else begin
                    w_ra         = 1'b1;
                    w_rb         = 1'b1;
                    w_next_state = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                w_rz         = ~NOP_FLAG;
                w_rm         = ~NOP_FLAG;
                w_next_state = ST_MEMORY;
            end
            ST_MEMORY: begin
                w_ma_sel = 1'b0;
                w_cmd    = w_mem_cmd;
                if (w_mem_cmd == 2'b00 || Mem_Ready) begin
                    w_ry         = 1'b1;
                    w_next_state = ST_WRITEBACK;
                    w_wait_next  = '0;
                end else if (w_to_hit) begin
                    w_next_state = ST_FAULT;
                end else begin
                    w_wait_next = r_wait + 1'b1;
                end
            end
            ST_WRITEBACK: begin
                w_rf_wr      = Writes_RF & ~NOP_FLAG;
                w_done       = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
                w_next_state = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state <= ST_FETCH;
            r_wait  <= '0;
            r_count <= '0;
        end else if (!Hold) begin
            r_state <= w_next_state;
            r_wait  <= w_wait_next;
            if (w_done) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Stall and reset silence every datapath side effect but leave Stage visible
    assign Stage       = r_state;
    assign IR_Enable   = w_ir & w_active;
    assign PC_Enable   = w_pc & w_active;
    assign RA_Enable   = w_ra & w_active;
    assign RB_Enable   = w_rb & w_active;
    assign RZ_Enable   = w_rz & w_active;
    assign RM_Enable   = w_rm & w_active;
    assign RY_Enable   = w_ry & w_active;
    assign RF_WRITE    = w_rf_wr & w_active;
    assign Instr_Done  = w_done & w_active;
    assign MEM_r_w_z_z = w_cmd & {2{w_active}};
    assign MA_Select   = Reset_n ? w_ma_sel : 1'b1;
    assign Mem_Fault   = w_fault & Reset_n;
    assign Instr_Count = r_count;

endmodule

// File: tb/tb_multicycle_stage_sequencer.sv
// tb/tb_multicycle_stage_sequencer.sv - directed self-checking bench for multicycle_stage_sequencer
module tb_multicycle_stage_sequencer;

    logic        Clock;
    logic        Reset_n;
    logic        Hold;
    logic        Mem_Ready;
    logic        NOP_FLAG;
    logic [1:0]  Mem_Access;
    logic        Writes_RF;

    logic [2:0]  Stage;
    logic        IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable, RM_Enable, RY_Enable, RF_WRITE;
    logic        MA_Select;
    logic [1:0]  MEM_r_w_z_z;
    logic        Instr_Done, Mem_Fault;
    logic [15:0] Instr_Count;

    logic [2:0]  d2_stage;
    logic        d2_ir, d2_pc, d2_ra, d2_rb, d2_rz, d2_rm, d2_ry, d2_rf;
    logic        d2_ma, d2_done, d2_fault;
    logic [1:0]  d2_cmd;
    logic [3:0]  d2_count;

    logic [8:0]  en_vec;
    logic [8:0]  d2_en_vec;

    int checks;
    int errors;

    localparam logic [8:0] E_F   = 9'b110000000;
    localparam logic [8:0] E_D   = 9'b001100000;
    localparam logic [8:0] E_E   = 9'b000011000;
    localparam logic [8:0] E_M   = 9'b000000100;
    localparam logic [8:0] E_W   = 9'b000000011;
    localparam logic [8:0] E_WN  = 9'b000000001;
    localparam logic [8:0] E_DN  = 9'b000000001;
    localparam logic [8:0] E_0   = 9'b000000000;

    assign en_vec    = {IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable, RM_Enable, RY_Enable, RF_WRITE, Instr_Done};
    assign d2_en_vec = {d2_ir, d2_pc, d2_ra, d2_rb, d2_rz, d2_rm, d2_ry, d2_rf, d2_done};

    multicycle_stage_sequencer u_dut (
        .Clock(Clock), .Reset_n(Reset_n), .Hold(Hold), .Mem_Ready(Mem_Ready),
        .NOP_FLAG(NOP_FLAG), .Mem_Access(Mem_Access), .Writes_RF(Writes_RF),
        .Stage(Stage), .IR_Enable(IR_Enable), .PC_Enable(PC_Enable),
        .RA_Enable(RA_Enable), .RB_Enable(RB_Enable), .RZ_Enable(RZ_Enable),
        .RM_Enable(RM_Enable), .RY_Enable(RY_Enable), .RF_WRITE(RF_WRITE),
        .MA_Select(MA_Select), .MEM_r_w_z_z(MEM_r_w_z_z), .Instr_Done(Instr_Done),
        .Mem_Fault(Mem_Fault), .Instr_Count(Instr_Count)
    );

    multicycle_stage_sequencer #(
        .MEM_TIMEOUT(3), .TO_W(2), .NOP_SKIP(0), .CNT_W(4)
    ) u_dut_walk (
        .Clock(Clock), .Reset_n(Reset_n), .Hold(Hold), .Mem_Ready(Mem_Ready),
        .NOP_FLAG(NOP_FLAG), .Mem_Access(Mem_Access), .Writes_RF(Writes_RF),
        .Stage(d2_stage), .IR_Enable(d2_ir), .PC_Enable(d2_pc),
        .RA_Enable(d2_ra), .RB_Enable(d2_rb), .RZ_Enable(d2_rz),
        .RM_Enable(d2_rm), .RY_Enable(d2_ry), .RF_WRITE(d2_rf),
        .MA_Select(d2_ma), .MEM_r_w_z_z(d2_cmd), .Instr_Done(d2_done),
        .Mem_Fault(d2_fault), .Instr_Count(d2_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic test_reset;
        @(negedge Clock);
        Reset_n = 1'b0; Hold = 1'b1; Mem_Ready = 1'b1; NOP_FLAG = 1'b0; Mem_Access = 2'b00; Writes_RF = 1'b1;
        #1;
        checks++; if (en_vec !== E_0) begin errors++; $display("FAIL reset_en: got %b expected %b", en_vec, E_0); end
        checks++; if (MEM_r_w_z_z !== 2'b00) begin errors++; $display("FAIL reset_cmd: got %b expected 00", MEM_r_w_z_z); end
        checks++; if (MA_Select !== 1'b1) begin errors++; $display("FAIL reset_ma_sel: got %b expected 1", MA_Select); end
        checks++; if (Mem_Fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", Mem_Fault); end
        @(posedge Clock); #1;
        checks++; if (Stage !== 3'd0) begin errors++; $display("FAIL reset_stage: got %0d expected 0", Stage); end
        checks++; if (Instr_Count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h expected 0000", Instr_Count); end
        checks++; if (d2_count !== 4'h0) begin errors++; $display("FAIL reset_count_walk: got %h expected 0", d2_count); end
        @(negedge Clock);
        Hold = 1'b0;
        #1;
        checks++; if (en_vec !== E_0) begin errors++; $display("FAIL reset_en_nohold: got %b expected %b", en_vec, E_0); end
        @(posedge Clock); #1;
    endtask

    task automatic test_alu;
        logic [2:0] xs [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [8:0] xe [5] = '{E_F, E_D, E_E, E_M, E_W};
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            Reset_n = 1'b1; Mem_Ready = 1'b1; Mem_Access = 2'b00; Writes_RF = 1'b1; NOP_FLAG = 1'b0;
            #1;
            checks++; if (Stage !== xs[i]) begin errors++; $display("FAIL alu_stage[%0d]: got %0d expected %0d", i, Stage, xs[i]); end
            checks++; if (en_vec !== xe[i]) begin errors++; $display("FAIL alu_en[%0d]: got %b expected %b", i, en_vec, xe[i]); end
            if (i == 0) begin
                checks++; if ({MA_Select, MEM_r_w_z_z} !== 3'b110) begin errors++; $display("FAIL alu_fetch_mem: got %b expected 110", {MA_Select, MEM_r_w_z_z}); end
            end
            if (i == 3) begin
                checks++; if ({MA_Select, MEM_r_w_z_z} !== 3'b000) begin errors++; $display("FAIL alu_mem_cmd: got %b expected 000", {MA_Select, MEM_r_w_z_z}); end
            end
        end
        @(posedge Clock); #1;
        checks++; if (Stage !== 3'd0) begin errors++; $display("FAIL alu_end_stage: got %0d expected 0", Stage); end
        checks++; if (Instr_Count !== 16'd1) begin errors++; $display("FAIL alu_count: got %0d expected 1", Instr_Count); end
    endtask

    task automatic test_load_wait;
        logic [2:0] xs [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        logic [8:0] xe [8] = '{E_F, E_D, E_E, E_0, E_0, E_0, E_M, E_W};
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            Mem_Access = 2'b10; Writes_RF = 1'b1; NOP_FLAG = 1'b0;
            Mem_Ready = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
            #1;
            checks++; if (Stage !== xs[i]) begin errors++; $display("FAIL load_stage[%0d]: got %0d expected %0d", i, Stage, xs[i]); end
            checks++; if (en_vec !== xe[i]) begin errors++; $display("FAIL load_en[%0d]: got %b expected %b", i, en_vec, xe[i]); end
            if (i >= 3 && i <= 6) begin
                checks++; if ({MA_Select, MEM_r_w_z_z} !== 3'b010) begin errors++; $display("FAIL load_mem_cmd[%0d]: got %b expected 010", i, {MA_Select, MEM_r_w_z_z}); end
            end
        end
        @(posedge Clock); #1;
        checks++; if (Stage !== 3'd0) begin errors++; $display("FAIL load_end_stage: got %0d expected 0", Stage); end
        checks++; if (Instr_Count !== 16'd2) begin errors++; $display("FAIL load_count: got %0d expected 2", Instr_Count); end
    endtask

    task automatic test_nop_skip;
        logic [2:0] xs [2] = '{3'd0, 3'd1};
        logic [8:0] xe [2] = '{E_F, E_DN};
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            NOP_FLAG = 1'b1; Mem_Access = 2'b00; Writes_RF = 1'b1; Mem_Ready = 1'b1;
            #1;
            checks++; if (Stage !== xs[i]) begin errors++; $display("FAIL nop_stage[%0d]: got %0d expected %0d", i, Stage, xs[i]); end
            checks++; if (en_vec !== xe[i]) begin errors++; $display("FAIL nop_en[%0d]: got %b expected %b", i, en_vec, xe[i]); end
        end
        @(posedge Clock); #1;
        checks++; if (Stage !== 3'd0) begin errors++; $display("FAIL nop_end_stage: got %0d expected 0", Stage); end
        checks++; if (Instr_Count !== 16'd3) begin errors++; $display("FAIL nop_count: got %0d expected 3", Instr_Count); end
    endtask

    task automatic test_hold;
        logic [2:0] xs [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4};
        logic [8:0] xe [8] = '{E_F, E_D, E_0, E_0, E_0, E_E, E_M, E_WN};
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            NOP_FLAG = 1'b0; Mem_Access = 2'b00; Writes_RF = 1'b0; Mem_Ready = 1'b1;
            Hold = (i >= 2 && i <= 4) ? 1'b1 : 1'b0;
            #1;
            checks++; if (Stage !== xs[i]) begin errors++; $display("FAIL hold_stage[%0d]: got %0d expected %0d", i, Stage, xs[i]); end
            checks++; if (en_vec !== xe[i]) begin errors++; $display("FAIL hold_en[%0d]: got %b expected %b", i, en_vec, xe[i]); end
        end
        @(posedge Clock); #1;
        Hold = 1'b0;
        checks++; if (Stage !== 3'd0) begin errors++; $display("FAIL hold_end_stage: got %0d expected 0", Stage); end
        checks++; if (Instr_Count !== 16'd4) begin errors++; $display("FAIL hold_count: got %0d expected 4", Instr_Count); end
    endtask

    task automatic test_timeout;
        for (int i = 0; i < 18; i++) begin
            @(negedge Clock);
            NOP_FLAG = 1'b0; Mem_Access = 2'b00; Writes_RF = 1'b1;
            Mem_Ready = (i < 15) ? 1'b0 : 1'b1;
            #1;
            if (i < 15) begin
                checks++; if (Stage !== 3'd0) begin errors++; $display("FAIL timeout_wait_stage[%0d]: got %0d expected 0", i, Stage); end
                checks++; if (MEM_r_w_z_z !== 2'b10) begin errors++; $display("FAIL timeout_wait_cmd[%0d]: got %b expected 10", i, MEM_r_w_z_z); end
            end else begin
                checks++; if (Stage !== 3'd7) begin errors++; $display("FAIL timeout_fault_stage[%0d]: got %0d expected 7", i, Stage); end
                checks++; if ({Mem_Fault, MEM_r_w_z_z} !== 3'b100) begin errors++; $display("FAIL timeout_fault_out[%0d]: got %b expected 100", i, {Mem_Fault, MEM_r_w_z_z}); end
                checks++; if (Instr_Count !== 16'd4) begin errors++; $display("FAIL timeout_count[%0d]: got %0d expected 4", i, Instr_Count); end
            end
            checks++; if (en_vec !== E_0) begin errors++; $display("FAIL timeout_en[%0d]: got %b expected %b", i, en_vec, E_0); end
        end
        @(negedge Clock);
        Reset_n = 1'b0;
        #1;
        checks++; if (Mem_Fault !== 1'b0) begin errors++; $display("FAIL fault_reset_flag: got %b expected 0", Mem_Fault); end
        @(posedge Clock); #1;
        checks++; if (Stage !== 3'd0) begin errors++; $display("FAIL fault_reset_stage: got %0d expected 0", Stage); end
        checks++; if (Instr_Count !== 16'd0) begin errors++; $display("FAIL fault_reset_count: got %0d expected 0", Instr_Count); end
    endtask

    task automatic test_ready_final_cycle;
        logic [2:0] exp_stage;
        for (int i = 0; i < 19; i++) begin
            @(negedge Clock);
            Reset_n = 1'b1; NOP_FLAG = 1'b0; Mem_Access = 2'b00; Writes_RF = 1'b1;
            Mem_Ready = (i < 14) ? 1'b0 : 1'b1;
            exp_stage = (i <= 14) ? 3'd0 : 3'(i - 14);
            #1;
            checks++; if (Stage !== exp_stage) begin errors++; $display("FAIL ready_last_stage[%0d]: got %0d expected %0d", i, Stage, exp_stage); end
            if (i == 14) begin
                checks++; if (en_vec !== E_F) begin errors++; $display("FAIL ready_last_en: got %b expected %b", en_vec, E_F); end
            end
        end
        @(posedge Clock); #1;
        checks++; if (Instr_Count !== 16'd1) begin errors++; $display("FAIL ready_last_count: got %0d expected 1", Instr_Count); end
    endtask

    task automatic test_reset_mid_memory;
        logic [2:0] xs [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            Mem_Access = 2'b10; Writes_RF = 1'b1; NOP_FLAG = 1'b0;
            Mem_Ready = (i < 3) ? 1'b1 : 1'b0;
            #1;
            checks++; if (Stage !== xs[i]) begin errors++; $display("FAIL rstmem_stage[%0d]: got %0d expected %0d", i, Stage, xs[i]); end
        end
        @(negedge Clock);
        Reset_n = 1'b0; Mem_Ready = 1'b1;
        #1;
        checks++; if (en_vec !== E_0) begin errors++; $display("FAIL rstmem_en: got %b expected %b", en_vec, E_0); end
        checks++; if ({MA_Select, MEM_r_w_z_z} !== 3'b100) begin errors++; $display("FAIL rstmem_mem: got %b expected 100", {MA_Select, MEM_r_w_z_z}); end
        @(posedge Clock); #1;
        checks++; if (Stage !== 3'd0) begin errors++; $display("FAIL rstmem_stage_after: got %0d expected 0", Stage); end
        checks++; if (Instr_Count !== 16'd0) begin errors++; $display("FAIL rstmem_count: got %0d expected 0", Instr_Count); end
    endtask

    task automatic test_nop_walk_wrap;
        logic [2:0] xs [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [8:0] xe [5] = '{E_F, E_D, E_0, E_M, E_WN};
        for (int i = 0; i < 80; i++) begin
            @(negedge Clock);
            Reset_n = 1'b1; NOP_FLAG = 1'b1; Mem_Access = 2'b10; Writes_RF = 1'b1; Mem_Ready = 1'b1;
            #1;
            if (i < 5) begin
                checks++; if (d2_stage !== xs[i]) begin errors++; $display("FAIL walk_stage[%0d]: got %0d expected %0d", i, d2_stage, xs[i]); end
                checks++; if (d2_en_vec !== xe[i]) begin errors++; $display("FAIL walk_en[%0d]: got %b expected %b", i, d2_en_vec, xe[i]); end
            end
            if (i == 3) begin
                checks++; if (d2_cmd !== 2'b00) begin errors++; $display("FAIL walk_mem_cmd: got %b expected 00", d2_cmd); end
            end
            if (i == 74 || i == 79) begin
                @(posedge Clock); #1;
                checks++;
                if (d2_count !== ((i == 74) ? 4'hF : 4'h0)) begin
                    errors++; $display("FAIL walk_count_wrap[%0d]: got %h expected %h", i, d2_count, (i == 74) ? 4'hF : 4'h0);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset_n = 1'b0; Hold = 1'b0; Mem_Ready = 1'b0; NOP_FLAG = 1'b0; Mem_Access = 2'b00; Writes_RF = 1'b0;
        test_reset;
        test_alu;
        test_load_wait;
        test_nop_skip;
        test_hold;
        test_timeout;
        test_ready_final_cycle;
        test_reset_mid_memory;
        test_nop_walk_wrap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
